// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler: steers camera pixel writes into one of three
// frame banks and hands completed frames to the display only at VGA frame
// boundaries so the displayed picture never tears.
module frame_bank_scheduler #(
  parameter int FRAME_PIXELS = 76800,
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_en,
  input  logic              freeze,
  input  logic              cam_sof,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_wAddr,
  input  logic [DATA_W-1:0] cam_wData,
  input  logic              vga_frame_end,
  input  logic [ADDR_W-1:0] vga_rAddr,
  output logic              mem_we,
  output logic [ADDR_W+1:0] mem_wAddr,
  output logic [DATA_W-1:0] mem_wData,
  output logic [ADDR_W+1:0] mem_rAddr,
  output logic [1:0]        rd_bank,
  output logic [15:0]       frame_swaps,
  output logic [15:0]       frames_dropped,
  output logic              overrun
);

  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);

  localparam logic [0:0] S_WAIT_SOF = 1'b0;
  localparam logic [0:0] S_CAPTURE  = 1'b1;

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic [1:0]        r_wr_bank;
  logic [1:0]        r_rdy_bank;
  logic [1:0]        r_rd_bank;
  logic              r_rdy_valid;
  logic              r_mem_we;
  logic [ADDR_W+1:0] r_mem_wAddr;
  logic [DATA_W-1:0] r_mem_wData;
  logic [15:0]       r_frame_swaps;
  logic [15:0]       r_frames_dropped;
  logic              r_overrun;

  logic              w_capturing;
  logic              w_wr_try;
  logic              w_accept;
  logic              w_over;
  logic              w_close;
  logic              w_complete;
  logic              w_drop;
  logic [1:0]        w_cl_wr;
  logic [1:0]        w_cl_rdy;
  logic              w_cl_valid;
  logic              w_swap;

  // Decode write acceptance and frame close; cam_sof takes priority over cam_we.
  always_comb begin
    w_capturing = (r_state == S_CAPTURE);
    w_wr_try    = w_capturing && cam_we && !cam_sof;
    w_accept    = w_wr_try && (r_pix_cnt < FRAME_CNT);
    w_over      = w_wr_try && (r_pix_cnt >= FRAME_CNT);
    w_close     = w_capturing && cam_sof;
    w_complete  = w_close && (r_pix_cnt == FRAME_CNT);
    w_drop      = w_close && (r_pix_cnt != FRAME_CNT);
  end

  // Apply the frame close first, then decide the display swap on that result.
  always_comb begin
    w_cl_wr    = r_wr_bank;
    w_cl_rdy   = r_rdy_bank;
    w_cl_valid = r_rdy_valid;
    if (w_complete) begin
      w_cl_rdy   = r_wr_bank;
      w_cl_wr    = r_rdy_bank;
      w_cl_valid = 1'b1;
    end
    w_swap = vga_frame_end && w_cl_valid && !freeze;
  end

  // Writer FSM and per-frame pixel counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_WAIT_SOF;
      r_pix_cnt <= '0;
    end else begin
      if (cam_sof) begin
        if (capture_en) begin
          r_state   <= S_CAPTURE;
          r_pix_cnt <= '0;
        end else if (w_capturing) begin
          r_state <= S_WAIT_SOF;
        end
      end else if (w_accept) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
    end
  end

  // Bank rotation: writer/ready exchange on frame close, ready/display on swap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_bank   <= 2'd0;
      r_rdy_bank  <= 2'd1;
      r_rd_bank   <= 2'd2;
      r_rdy_valid <= 1'b0;
    end else begin
      r_wr_bank <= w_cl_wr;
      if (w_swap) begin
        r_rd_bank   <= w_cl_rdy;
        r_rdy_bank  <= r_rd_bank;
        r_rdy_valid <= 1'b0;
      end else begin
        r_rdy_bank  <= w_cl_rdy;
        r_rdy_valid <= w_cl_valid;
      end
    end
  end

  // Registered RAM write port, banked with the writer bank of the input cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_we    <= 1'b0;
      r_mem_wAddr <= '0;
      r_mem_wData <= '0;
    end else begin
      r_mem_we <= w_accept;
      if (w_accept) begin
        r_mem_wAddr <= {r_wr_bank, cam_wAddr};
        r_mem_wData <= cam_wData;
      end
    end
  end

  // Status counters (wrapping) and sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_swaps    <= '0;
      r_frames_dropped <= '0;
      r_overrun        <= 1'b0;
    end else begin
      if (w_swap) r_frame_swaps <= r_frame_swaps + 16'd1;
      if (w_drop) r_frames_dropped <= r_frames_dropped + 16'd1;
      if (w_over) r_overrun <= 1'b1;
    end
  end

  assign mem_we         = r_mem_we;
  assign mem_wAddr      = r_mem_wAddr;
  assign mem_wData      = r_mem_wData;
  assign mem_rAddr      = {r_rd_bank, vga_rAddr};
  assign rd_bank        = r_rd_bank;
  assign frame_swaps    = r_frame_swaps;
  assign frames_dropped = r_frames_dropped;
  assign overrun        = r_overrun;

endmodule
